// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    localparam int DATA_W          = 16;
    localparam int WAIT_CYCLES_DEF = 2;

endpackage

// File: rtl/rr_pick2.sv
// Two-way combinational round-robin pick; req[0] is the CPU, req[1] the debug port.
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       grant
);

    always_comb begin
        grant = OWN_CPU;
        if (req == 2'b10) begin
            grant = OWN_DBG;
        end else if (req == 2'b11) begin
            // On a tie, the port that did not win last time goes next
            grant = ~last_owner;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a CPU port and a debug/loader port onto one asynchronous SRAM,
// holding OE/WE low for WAIT_CYCLES cycles per access.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,

    output logic [15:0] ADDR,
    output logic [15:0] Data_to_SRAM,
    input  logic [15:0] Data_from_SRAM,
    output logic        OE,
    output logic        WE,
    output logic        busy,
    output logic        owner
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    arb_state_t  state;
    arb_state_t  state_nxt;
    logic [3:0]  cnt;
    logic [15:0] lat_addr;
    logic        lat_we;
    logic [15:0] lat_wdata;
    logic        owner_q;
    logic        last_owner;
    logic        grant;
    logic        any_req;

    assign any_req = cpu_req | dbg_req;
    assign ADDR    = lat_addr;
    assign owner   = owner_q;

    rr_pick2 u_pick (
        .req        ({dbg_req, cpu_req}),
        .last_owner (last_owner),
        .grant      (grant)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        OE           = 1'b1;
        WE           = 1'b1;
        Data_to_SRAM = '0;
        cpu_ack      = 1'b0;
        dbg_ack      = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                // Exactly one strobe is driven low, chosen by the latched access type
                OE = lat_we;
                WE = ~lat_we;
                if (lat_we) begin
                    Data_to_SRAM = lat_wdata;
                end
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cpu_ack   = (owner_q == OWN_CPU);
                dbg_ack   = (owner_q == OWN_DBG);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt        <= 4'd0;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            owner_q    <= OWN_DBG;
            last_owner <= OWN_DBG;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_q   <= grant;
                        cnt       <= CNT_LOAD;
                        lat_addr  <= (grant == OWN_DBG) ? dbg_addr  : cpu_addr;
                        lat_we    <= (grant == OWN_DBG) ? dbg_we    : cpu_we;
                        lat_wdata <= (grant == OWN_DBG) ? dbg_wdata : cpu_wdata;
                    end
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            if (owner_q == OWN_CPU) begin
                                cpu_rdata <= Data_from_SRAM;
                            end else begin
                                dbg_rdata <= Data_from_SRAM;
                            end
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    last_owner <= owner_q;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter at WAIT_CYCLES of 2, 1 and 15.
module tb_sram_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [15:0] Data_from_SRAM;

    logic        cpu_req, cpu_we, dbg_req, dbg_we;
    logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic        cpu_ack, dbg_ack, OE, WE, busy, owner;
    logic [15:0] cpu_rdata, dbg_rdata, ADDR, Data_to_SRAM;

    logic        a_cpu_req, a_dbg_req, a_cpu_ack, a_dbg_ack, a_OE, a_WE, a_busy, a_owner;
    logic [15:0] a_cpu_rdata, a_dbg_rdata, a_ADDR, a_Data_to_SRAM;
    logic        b_cpu_req, b_dbg_req, b_cpu_ack, b_dbg_ack, b_OE, b_WE, b_busy, b_owner;
    logic [15:0] b_cpu_rdata, b_dbg_rdata, b_ADDR, b_Data_to_SRAM;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    sram_arbiter #(.WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE(OE), .WE(WE), .busy(busy), .owner(owner)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(a_cpu_req), .cpu_we(1'b0), .cpu_addr(16'h0021), .cpu_wdata(16'h0000),
        .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
        .dbg_req(a_dbg_req), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_ack(a_dbg_ack), .dbg_rdata(a_dbg_rdata),
        .ADDR(a_ADDR), .Data_to_SRAM(a_Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE(a_OE), .WE(a_WE), .busy(a_busy), .owner(a_owner)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) dut_w15 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(b_cpu_req), .cpu_we(1'b0), .cpu_addr(16'h0F00), .cpu_wdata(16'h0000),
        .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
        .dbg_req(b_dbg_req), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_ack(b_dbg_ack), .dbg_rdata(b_dbg_rdata),
        .ADDR(b_ADDR), .Data_to_SRAM(b_Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
        .OE(b_OE), .WE(b_WE), .busy(b_busy), .owner(b_owner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
    endtask

    initial begin
        int ack_at;
        int oe_lo;
        int n_ack;
        int ack_step [4];
        logic ack_who [4];
        logic any_ack;

        Reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        a_cpu_req = 0; a_dbg_req = 0; b_cpu_req = 0; b_dbg_req = 0;
        Data_from_SRAM = 16'h0;
        do_reset();

        chk("rst_oe", OE, 1);
        chk("rst_we", WE, 1);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 1);
        chk("rst_addr", ADDR, 0);
        chk("rst_d2s", Data_to_SRAM, 0);
        chk("rst_rdata", {cpu_rdata, dbg_rdata}, 0);

        // CPU read 0x0010 -> 0xBEEF
        Data_from_SRAM = 16'hBEEF;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010; cpu_wdata = 16'h7777;
        step();
        chk("rd_acc1_oe", OE, 0);
        chk("rd_acc1_we", WE, 1);
        chk("rd_acc1_addr", ADDR, 16'h0010);
        chk("rd_acc1_d2s", Data_to_SRAM, 0);
        chk("rd_acc1_own", owner, 0);
        chk("rd_acc1_ack", cpu_ack, 0);
        step();
        chk("rd_acc2_oe", OE, 0);
        chk("rd_acc2_we", WE, 1);
        step();
        chk("rd_done_ack", cpu_ack, 1);
        chk("rd_done_oe", OE, 1);
        chk("rd_done_rdata", cpu_rdata, 16'hBEEF);
        cpu_req = 0;
        step();
        chk("rd_idle_ack", cpu_ack, 0);
        chk("rd_idle_busy", busy, 0);
        chk("rd_idle_addr", ADDR, 16'h0010);

        // Debug write 0x0200 <- 0x1234
        dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0200; dbg_wdata = 16'h1234;
        step();
        chk("wr_acc1_we", WE, 0);
        chk("wr_acc1_oe", OE, 1);
        chk("wr_acc1_addr", ADDR, 16'h0200);
        chk("wr_acc1_d2s", Data_to_SRAM, 16'h1234);
        chk("wr_acc1_own", owner, 1);
        step();
        chk("wr_acc2_we", WE, 0);
        step();
        chk("wr_done_ack", dbg_ack, 1);
        chk("wr_done_cack", cpu_ack, 0);
        chk("wr_done_we", WE, 1);
        chk("wr_done_d2s", Data_to_SRAM, 0);
        chk("wr_dbg_rdata", dbg_rdata, 0);
        chk("wr_cpu_rdata", cpu_rdata, 16'hBEEF);
        dbg_req = 0; dbg_we = 0;
        step();

        // Both ports requesting continuously from reset
        do_reset();
        chk("rst2_rdata", cpu_rdata, 0);
        Data_from_SRAM = 16'hA5A5;
        cpu_req = 1; cpu_we = 0; dbg_req = 1; dbg_we = 0;
        n_ack = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            if (cpu_ack && dbg_ack) chk("rr_dual_ack", 1, 0);
            if ((cpu_ack || dbg_ack) && n_ack < 4) begin
                ack_step[n_ack] = i;
                ack_who[n_ack]  = dbg_ack;
                n_ack++;
            end
        end
        cpu_req = 0; dbg_req = 0;
        chk("rr_n_ack", n_ack, 4);
        for (int k = 0; k < 4; k++) begin
            if (k < n_ack) begin
                chk($sformatf("rr_who%0d", k), ack_who[k], k % 2);
                chk($sformatf("rr_step%0d", k), ack_step[k], 3 + 4 * k);
            end
        end
        chk("rr_rdata", cpu_rdata, 16'hA5A5);

        // Reset in the second ACCESS cycle of a CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
        step();
        step();
        chk("ab_acc2_oe", OE, 0);
        chk("ab_acc2_busy", busy, 1);
        Reset = 1;
        step();
        chk("ab_oe", OE, 1);
        chk("ab_busy", busy, 0);
        chk("ab_ack", cpu_ack, 0);
        chk("ab_rdata", cpu_rdata, 0);
        Reset = 0; cpu_req = 0;
        any_ack = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (cpu_ack) any_ack = 1;
        end
        chk("ab_no_ack", any_ack, 0);

        // cpu_req dropped after one ACCESS cycle
        Data_from_SRAM = 16'h5A5A;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0033;
        step();
        cpu_req = 0;
        n_ack = 0; ack_at = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (cpu_ack) begin
                n_ack++;
                ack_at = i;
            end
        end
        chk("drop_n_ack", n_ack, 1);
        chk("drop_ack_at", ack_at, 2);
        chk("drop_rdata", cpu_rdata, 16'h5A5A);

        // WAIT_CYCLES = 1
        Data_from_SRAM = 16'h1111;
        a_cpu_req = 1;
        ack_at = 0; oe_lo = 0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (a_OE == 1'b0) oe_lo++;
            if (a_cpu_ack) begin
                ack_at = i;
                a_cpu_req = 0;
                break;
            end
        end
        a_cpu_req = 0;
        chk("w1_ack_at", ack_at, 2);
        chk("w1_oe_lo", oe_lo, 1);
        chk("w1_rdata", a_cpu_rdata, 16'h1111);

        // WAIT_CYCLES = 15
        Data_from_SRAM = 16'h2222;
        b_cpu_req = 1;
        ack_at = 0; oe_lo = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (b_OE == 1'b0) oe_lo++;
            if (b_cpu_ack) begin
                ack_at = i;
                b_cpu_req = 0;
                break;
            end
        end
        b_cpu_req = 0;
        chk("w15_ack_at", ack_at, 16);
        chk("w15_oe_lo", oe_lo, 15);
        chk("w15_rdata", b_cpu_rdata, 16'h2222);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one clock and one synchronous, active-high reset; all state changes on rising Clk.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of cycles OE/WE is held before the access completes (legal range 1..15).
REQ-003 Clk  input  1  system clock.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 cpu_req  input  1  CPU access request, held until cpu_ack.
REQ-006 cpu_we  input  1  CPU access type: 1 = write, 0 = read.
REQ-007 cpu_addr  input  16  CPU address.
REQ-008 cpu_wdata  input  16  CPU write data.
REQ-009 cpu_ack  output  1  one-cycle completion pulse to the CPU.
REQ-010 cpu_rdata  output  16  CPU read data, valid from the cpu_ack cycle onward.
REQ-011 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  (1, 1, 16, 16, 1, 16)  debug/loader port; same semantics as the CPU port.
REQ-012 ADDR  output  16  SRAM address.
REQ-013 Data_to_SRAM  output  16  SRAM write data.
REQ-014 Data_from_SRAM  input  16  SRAM read data.
REQ-015 OE  output  1  SRAM output enable, active-low.
REQ-016 WE  output  1  SRAM write enable, active-low.
REQ-017 busy  output  1  high in any state other than IDLE.
REQ-018 owner  output  1  current or last grantee: 0 = CPU, 1 = debug.

Function
REQ-019 The FSM SHALL have exactly three states, IDLE, ACCESS and DONE, with transitions IDLE->ACCESS->DONE->IDLE.
REQ-020 In IDLE with any request pending, the block SHALL grant one port and latch that port's addr, we and wdata into internal registers.
REQ-021 On the same edge it SHALL load the wait counter with WAIT_CYCLES-1 and enter ACCESS.
REQ-022 Arbitration SHALL be round-robin: when only one port requests, that port wins; when both request, the port that did not win last wins.
REQ-023 In ACCESS, ADDR SHALL equal the latched address.
REQ-024 In ACCESS, OE SHALL be 0 for a read and WE SHALL be 0 for a write; OE and WE SHALL never be 0 simultaneously.
REQ-025 In ACCESS, Data_to_SRAM SHALL equal the latched wdata for a write and 0 otherwise.
REQ-026 In ACCESS, the counter SHALL decrement every cycle; at counter==0 the block SHALL capture Data_from_SRAM into the owner's rdata (reads only) and enter DONE.
REQ-027 In DONE, OE and WE SHALL be 1, the owner's ack SHALL be 1 for exactly one cycle, last_owner SHALL update, and the next state SHALL be IDLE.
REQ-028 Latency: a request sampled in IDLE at edge k SHALL produce ack high during the cycle after edge k+WAIT_CYCLES; peak throughput is one access per WAIT_CYCLES+2 cycles.
REQ-029 Requests and input changes arriving in ACCESS or DONE SHALL be ignored until the next IDLE.
REQ-030 Deassertion of req mid-access SHALL NOT abort the access; the ack is still issued.
REQ-031 rdata of a port SHALL hold its value until that port's next read completes; writes SHALL NOT change rdata.
REQ-032 ADDR SHALL hold its last latched value in IDLE and DONE.
REQ-033 Data_to_SRAM SHALL be 0 outside ACCESS.
REQ-034 A port SHALL NOT receive ack in the cycle immediately after its previous ack.

Reset
REQ-035 On Reset, the block SHALL enter IDLE with OE=1, WE=1, cpu_ack=0, dbg_ack=0, cpu_rdata=0, dbg_rdata=0, ADDR=0, Data_to_SRAM=0, busy=0, counter=0.
REQ-036 On Reset, last_owner and owner SHALL be set to 1, so the CPU wins the first tie.
REQ-037 A Reset asserted in ACCESS or DONE SHALL abort the access with no ack issued and rdata cleared; Reset SHALL take priority over all other events.

Structure
REQ-038 Package sram_arb_pkg SHALL hold the state enum {IDLE, ACCESS, DONE}, the owner constants OWN_CPU=0 and OWN_DBG=1, and the default WAIT_CYCLES.
REQ-039 A sub-module rr_pick2 SHALL hold the 2-way combinational round-robin pick (inputs req[1:0] and last_owner; output grant); all registers SHALL stay in sram_arbiter.

Verification
REQ-040 CPU read, addr 0x0010, SRAM returns 0xBEEF, WAIT_CYCLES=2 -> OE=0 for 2 cycles, then cpu_ack for 1 cycle with cpu_rdata=0xBEEF; WE stays 1.
REQ-041 dbg write, addr 0x0200, data 0x1234 -> WE=0 for WAIT_CYCLES cycles with ADDR=0x0200 and Data_to_SRAM=0x1234, then dbg_ack; dbg_rdata unchanged.
REQ-042 Both ports request continuously from reset -> grant order CPU, DBG, CPU, DBG; acks are 4 cycles apart (WAIT_CYCLES=2).
REQ-043 Reset asserted in the second ACCESS cycle of a CPU read -> next cycle in IDLE with OE=1 and no cpu_ack ever pulses.
REQ-044 cpu_req dropped after 1 ACCESS cycle -> access completes and cpu_ack still pulses once.
REQ-045 WAIT_CYCLES=1, CPU read -> ack 2 cycles after the grant edge; WAIT_CYCLES=15 -> OE low for exactly 15 cycles.
